// File: rtl/fifo_write_arbiter.sv
// Round-robin, message-granular arbiter sharing one FIFO write port between N_REQ producers.
// A grant lasts until the producer's last beat or until MAX_BURST beats force a release.
module fifo_write_arbiter #(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      fifo_write_en,
  output logic [DATA_W-1:0]         fifo_write_data,
  input  logic                      fifo_full,
  output logic                      status_busy,
  output logic [$clog2(N_REQ)-1:0]  status_grant_id,
  output logic                      status_split
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            split_q, split_d;

  logic [GW-1:0]   pick_s;
  logic            found_s;
  logic            xfer_s;
  logic            cap_s;
  logic            rel_s;
  logic [GW-1:0]   next_g_s;

  // Round-robin pick: scan from p downwards in priority so the lowest offset wins.
  always_comb begin
    found_s = |req_valid;
    pick_s  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pick_s = req_valid[(int'(p_q) + k) % N_REQ] ? GW'((int'(p_q) + k) % N_REQ) : pick_s;
    end
  end

  // Transfer and release qualifiers for the granted requester.
  always_comb begin
    xfer_s   = (state_q == GRANT) && req_valid[g_q] && !fifo_full;
    cap_s    = (cnt_q == CW'(MAX_BURST - 1));
    rel_s    = xfer_s && (req_last[g_q] || cap_s);
    next_g_s = (g_q == GW'(N_REQ - 1)) ? '0 : g_q + GW'(1);
  end

  // Next-state logic; a cap release only flags a split when the beat was not also last.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    split_d = split_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = GRANT;
          g_d     = pick_s;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (rel_s) begin
          state_d = IDLE;
          p_d     = next_g_s;
          cnt_d   = '0;
          split_d = split_q | !req_last[g_q];
        end else if (xfer_s) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      split_q <= split_d;
    end
  end

  // Combinational pass-through so a full FIFO stalls with no added latency.
  always_comb begin
    req_ready       = '0;
    fifo_write_en   = 1'b0;
    fifo_write_data = '0;
    if (state_q == GRANT) begin
      req_ready[g_q]  = !fifo_full;
      fifo_write_en   = req_valid[g_q] && !fifo_full;
      fifo_write_data = req_data[g_q*DATA_W +: DATA_W];
    end else begin
      req_ready       = '0;
      fifo_write_en   = 1'b0;
      fifo_write_data = '0;
    end
  end

  assign status_busy     = (state_q == GRANT);
  assign status_grant_id = g_q;
  assign status_split    = split_q;

endmodule
